// File: rtl/prog_loader_encoder.sv
// Streaming instruction encoder/loader: validates each opcode, packs {op, arg} into a
// machine word and writes the program sequentially into instruction memory from address 0.
module prog_loader_encoder #(
    parameter int IW  = 9,
    parameter int OPW = 4,
    parameter int AW  = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic           InValid,
    output logic           InReady,
    input  logic [OPW-1:0] InOp,
    input  logic [4:0]     InArg,
    input  logic           InLast,
    output logic           WrEn,
    output logic [AW-1:0]  WrAddr,
    output logic [IW-1:0]  WrData,
    output logic           Busy,
    output logic           Done,
    output logic           Err,
    output logic [1:0]     ErrCode,
    output logic [AW:0]    Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Highest legal opcode (NEQ); 14 and 15 are unassigned in the instruction map.
    localparam logic [OPW-1:0] LAST_OP = OPW'(13);

    state_t          stateReg, stateNext;
    logic [AW-1:0]   ptrReg, ptrNext;
    logic [AW:0]     countReg, countNext;
    logic            errReg, errNext;
    logic [1:0]      errCodeReg, errCodeNext;
    logic            wrEnReg, wrEnNext;
    logic [AW-1:0]   wrAddrReg, wrAddrNext;
    logic [IW-1:0]   wrDataReg, wrDataNext;
    logic            readyReg, busyReg, doneReg;
    logic            accept;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg   <= IDLE;
            ptrReg     <= '0;
            countReg   <= '0;
            errReg     <= 1'b0;
            errCodeReg <= 2'd0;
            wrEnReg    <= 1'b0;
            wrAddrReg  <= '0;
            wrDataReg  <= '0;
            readyReg   <= 1'b0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            ptrReg     <= ptrNext;
            countReg   <= countNext;
            errReg     <= errNext;
            errCodeReg <= errCodeNext;
            wrEnReg    <= wrEnNext;
            wrAddrReg  <= wrAddrNext;
            wrDataReg  <= wrDataNext;
            // Status outputs are flops fed from the next state, so they carry no path from InValid.
            readyReg   <= (stateNext == LOAD);
            busyReg    <= (stateNext == LOAD);
            doneReg    <= (stateNext == DONE);
        end
    end

    always_comb begin
        stateNext   = stateReg;
        ptrNext     = ptrReg;
        countNext   = countReg;
        errNext     = errReg;
        errCodeNext = errCodeReg;
        wrEnNext    = 1'b0;
        wrAddrNext  = wrAddrReg;
        wrDataNext  = wrDataReg;
        accept      = InValid && readyReg;

        case (stateReg)
            IDLE, ERROR: begin
                if (Start) begin
                    stateNext   = LOAD;
                    ptrNext     = '0;
                    countNext   = '0;
                    errNext     = 1'b0;
                    errCodeNext = 2'd0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (InOp <= LAST_OP) begin
                        wrEnNext   = 1'b1;
                        wrAddrNext = ptrReg;
                        wrDataNext = {InOp, InArg};
                        ptrNext    = ptrReg + 1'b1;
                        countNext  = countReg + 1'b1;
                        if (InLast) begin
                            stateNext = DONE;
                        end else if (ptrReg == {AW{1'b1}}) begin
                            // Last address filled with more program still to come.
                            stateNext   = ERROR;
                            errNext     = 1'b1;
                            errCodeNext = 2'd2;
                        end
                    end else begin
                        stateNext   = ERROR;
                        errNext     = 1'b1;
                        errCodeNext = 2'd1;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign InReady = readyReg;
    assign Busy    = busyReg;
    assign Done    = doneReg;
    assign WrEn    = wrEnReg;
    assign WrAddr  = wrAddrReg;
    assign WrData  = wrDataReg;
    assign Err     = errReg;
    assign ErrCode = errCodeReg;
    assign Count   = countReg;

endmodule

// File: tb/tb_prog_loader_encoder.sv
// Directed bench for prog_loader_encoder: a default instance (AW=8) and a tiny AW=2
// instance for the overflow path, sharing clock, reset and beat inputs.
module tb_prog_loader_encoder;

    logic       Clk;
    logic       Reset;
    logic       startA, startB;
    logic       InValid;
    logic [3:0] InOp;
    logic [4:0] InArg;
    logic       InLast;

    logic       aInReady, aWrEn, aBusy, aDone, aErr;
    logic [7:0] aWrAddr;
    logic [8:0] aWrData;
    logic [1:0] aErrCode;
    logic [8:0] aCount;

    logic       bInReady, bWrEn, bBusy, bDone, bErr;
    logic [1:0] bWrAddr;
    logic [8:0] bWrData;
    logic [1:0] bErrCode;
    logic [2:0] bCount;

    int checks   = 0;
    int failures = 0;

    prog_loader_encoder #(.IW(9), .OPW(4), .AW(8)) dutA (
        .Clk(Clk), .Reset(Reset), .Start(startA), .InValid(InValid), .InReady(aInReady),
        .InOp(InOp), .InArg(InArg), .InLast(InLast), .WrEn(aWrEn), .WrAddr(aWrAddr),
        .WrData(aWrData), .Busy(aBusy), .Done(aDone), .Err(aErr), .ErrCode(aErrCode),
        .Count(aCount)
    );

    prog_loader_encoder #(.IW(9), .OPW(4), .AW(2)) dutB (
        .Clk(Clk), .Reset(Reset), .Start(startB), .InValid(InValid), .InReady(bInReady),
        .InOp(InOp), .InArg(InArg), .InLast(InLast), .WrEn(bWrEn), .WrAddr(bWrAddr),
        .WrData(bWrData), .Busy(bBusy), .Done(bDone), .Err(bErr), .ErrCode(bErrCode),
        .Count(bCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; startA = 0; startB = 0; InValid = 0; InOp = 0; InArg = 0; InLast = 0;
        #2;
        checks++;
        if ({aInReady, aWrEn, aWrAddr, aWrData, aBusy, aDone, aErr, aErrCode, aCount} !== 33'd0) begin
            failures++;
            $display("FAIL reset_a: outputs=%h expected 0", {aInReady, aWrEn, aWrAddr, aWrData, aBusy, aDone, aErr, aErrCode, aCount});
        end
        checks++;
        if ({bInReady, bWrEn, bWrAddr, bWrData, bBusy, bDone, bErr, bErrCode, bCount} !== 21'd0) begin
            failures++;
            $display("FAIL reset_b: outputs=%h expected 0", {bInReady, bWrEn, bWrAddr, bWrData, bBusy, bDone, bErr, bErrCode, bCount});
        end
        tick(); tick();
        Reset = 1'b0;
        tick();
        checks++;
        if ({aInReady, aWrEn, aBusy, aDone, aErr} !== 5'd0) begin
            failures++;
            $display("FAIL idle_after_reset: rdy/wr/busy/done/err=%b expected 00000", {aInReady, aWrEn, aBusy, aDone, aErr});
        end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3] = '{4'd11, 4'd4, 4'd13};
        logic [4:0] args[3] = '{5'd3, 5'd5, 5'd1};
        logic [8:0] exp [3] = '{9'h163, 9'h085, 9'h1A1};
        // Start with a beat already offered: it must not be consumed in IDLE.
        startA = 1; InValid = 1; InOp = ops[0]; InArg = args[0]; InLast = 0;
        tick();
        startA = 0;
        checks++;
        if (aInReady !== 1'b1 || aBusy !== 1'b1 || aWrEn !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load_entry: InReady=%b Busy=%b WrEn=%b expected 1 1 0", aInReady, aBusy, aWrEn);
        end
        for (int i = 0; i < 3; i++) begin
            InOp = ops[i]; InArg = args[i]; InLast = (i == 2);
            tick();
            checks++;
            if (aWrEn !== 1'b1 || aWrAddr !== 8'(i) || aWrData !== exp[i] || aDone !== (i == 2)) begin
                failures++;
                $display("FAIL b2b_write%0d: WrEn=%b WrAddr=%0d WrData=%h Done=%b expected 1 %0d %h %b",
                         i, aWrEn, aWrAddr, aWrData, aDone, i, exp[i], (i == 2));
            end
            $display("b2b beat %0d: addr=%0d data=%h", i, aWrAddr, aWrData);
        end
        InValid = 0; InLast = 0;
        tick();
        checks++;
        if (aWrEn !== 1'b0 || aDone !== 1'b0 || aBusy !== 1'b0 || aInReady !== 1'b0 || aCount !== 9'd3) begin
            failures++;
            $display("FAIL b2b_end: WrEn=%b Done=%b Busy=%b InReady=%b Count=%0d expected 0 0 0 0 3",
                     aWrEn, aDone, aBusy, aInReady, aCount);
        end
    endtask

    task automatic test_illegal();
        startA = 1; InValid = 1; InOp = 4'd2; InArg = 5'd2; InLast = 0;
        tick();
        startA = 0;
        tick();
        checks++;
        if (aWrEn !== 1'b1 || aWrAddr !== 8'd0 || aWrData !== 9'h042 || aErr !== 1'b0) begin
            failures++;
            $display("FAIL illegal_first_write: WrEn=%b WrAddr=%0d WrData=%h Err=%b expected 1 0 042 0",
                     aWrEn, aWrAddr, aWrData, aErr);
        end
        InOp = 4'b1110; InArg = 5'd0;
        tick();
        checks++;
        if (aWrEn !== 1'b0 || aErr !== 1'b1 || aErrCode !== 2'd1 || aInReady !== 1'b0 || aCount !== 9'd1) begin
            failures++;
            $display("FAIL illegal_detect: WrEn=%b Err=%b ErrCode=%0d InReady=%b Count=%0d expected 0 1 1 0 1",
                     aWrEn, aErr, aErrCode, aInReady, aCount);
        end
        InOp = 4'd3; InArg = 5'd1;
        tick(); tick();
        checks++;
        if (aWrEn !== 1'b0 || aErr !== 1'b1 || aErrCode !== 2'd1 || aCount !== 9'd1 || aBusy !== 1'b0) begin
            failures++;
            $display("FAIL illegal_hold: WrEn=%b Err=%b ErrCode=%0d Count=%0d Busy=%b expected 0 1 1 1 0",
                     aWrEn, aErr, aErrCode, aCount, aBusy);
        end
        InValid = 0;
        $display("test_illegal done: ErrCode=%0d Count=%0d", aErrCode, aCount);
    endtask

    task automatic test_recover();
        // Beat offered alongside Start in ERROR must not be consumed on that edge.
        startA = 1; InValid = 1; InOp = 4'd1; InArg = 5'd7; InLast = 1;
        tick();
        startA = 0;
        checks++;
        if (aErr !== 1'b0 || aErrCode !== 2'd0 || aInReady !== 1'b1 || aCount !== 9'd0 || aWrEn !== 1'b0) begin
            failures++;
            $display("FAIL recover_clear: Err=%b ErrCode=%0d InReady=%b Count=%0d WrEn=%b expected 0 0 1 0 0",
                     aErr, aErrCode, aInReady, aCount, aWrEn);
        end
        tick();
        checks++;
        if (aWrEn !== 1'b1 || aWrAddr !== 8'd0 || aWrData !== 9'h027 || aDone !== 1'b1 || aCount !== 9'd1) begin
            failures++;
            $display("FAIL recover_write: WrEn=%b WrAddr=%0d WrData=%h Done=%b Count=%0d expected 1 0 027 1 1",
                     aWrEn, aWrAddr, aWrData, aDone, aCount);
        end
        InValid = 0; InLast = 0;
        tick();
        checks++;
        if (aDone !== 1'b0 || aWrEn !== 1'b0 || aBusy !== 1'b0) begin
            failures++;
            $display("FAIL recover_end: Done=%b WrEn=%b Busy=%b expected 0 0 0", aDone, aWrEn, aBusy);
        end
        $display("test_recover done: data=%h", aWrData);
    endtask

    task automatic test_gapped();
        logic [8:0] exp[3] = '{9'h0A0, 9'h0C1, 9'h0E2};
        startA = 1;
        tick();
        startA = 0;
        for (int i = 0; i < 3; i++) begin
            InValid = 1; InOp = 4'(i + 5); InArg = 5'(i); InLast = (i == 2);
            tick();
            InValid = 0; InLast = 0;
            checks++;
            if (aWrEn !== 1'b1 || aWrAddr !== 8'(i) || aWrData !== exp[i]) begin
                failures++;
                $display("FAIL gap_write%0d: WrEn=%b WrAddr=%0d WrData=%h expected 1 %0d %h",
                         i, aWrEn, aWrAddr, aWrData, i, exp[i]);
            end
            $display("gap beat %0d: addr=%0d data=%h", i, aWrAddr, aWrData);
            for (int b = 0; b < 2; b++) begin
                tick();
                checks++;
                if (aWrEn !== 1'b0 || (i < 2 && aInReady !== 1'b1)) begin
                    failures++;
                    $display("FAIL gap_bubble%0d_%0d: WrEn=%b InReady=%b expected 0 %b",
                             i, b, aWrEn, aInReady, (i < 2));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        startA = 1;
        tick();
        startA = 0;
        InValid = 1; InOp = 4'd2; InArg = 5'd9;
        tick();
        InValid = 0;
        checks++;
        if (aWrEn !== 1'b1 || aWrData !== 9'h049) begin
            failures++;
            $display("FAIL areset_pre: WrEn=%b WrData=%h expected 1 049", aWrEn, aWrData);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({aInReady, aWrEn, aWrAddr, aWrData, aBusy, aDone, aErr, aErrCode, aCount} !== 33'd0) begin
            failures++;
            $display("FAIL areset_immediate: outputs=%h expected 0",
                     {aInReady, aWrEn, aWrAddr, aWrData, aBusy, aDone, aErr, aErrCode, aCount});
        end
        tick();
        Reset = 1'b0;
        startA = 1;
        tick();
        startA = 0;
        InValid = 1; InOp = 4'd3; InArg = 5'd4; InLast = 1;
        tick();
        InValid = 0; InLast = 0;
        checks++;
        if (aWrEn !== 1'b1 || aWrAddr !== 8'd0 || aWrData !== 9'h064 || aCount !== 9'd1) begin
            failures++;
            $display("FAIL areset_restart: WrEn=%b WrAddr=%0d WrData=%h Count=%0d expected 1 0 064 1",
                     aWrEn, aWrAddr, aWrData, aCount);
        end
        tick();
        $display("test_async_reset done");
    endtask

    task automatic test_overflow();
        logic [8:0] exp[4] = '{9'h001, 9'h022, 9'h043, 9'h064};
        startB = 1;
        tick();
        startB = 0;
        InValid = 1; InLast = 0;
        for (int i = 0; i < 5; i++) begin
            InOp = 4'(i); InArg = 5'(i + 1);
            tick();
            if (i < 4) begin
                checks++;
                if (bWrEn !== 1'b1 || bWrAddr !== 2'(i) || bWrData !== exp[i]) begin
                    failures++;
                    $display("FAIL ovf_write%0d: WrEn=%b WrAddr=%0d WrData=%h expected 1 %0d %h",
                             i, bWrEn, bWrAddr, bWrData, i, exp[i]);
                end
                $display("ovf beat %0d: addr=%0d data=%h", i, bWrAddr, bWrData);
            end else begin
                checks++;
                if (bWrEn !== 1'b0 || bErr !== 1'b1 || bErrCode !== 2'd2 || bInReady !== 1'b0 || bCount !== 3'd4) begin
                    failures++;
                    $display("FAIL ovf_stop: WrEn=%b Err=%b ErrCode=%0d InReady=%b Count=%0d expected 0 1 2 0 4",
                             bWrEn, bErr, bErrCode, bInReady, bCount);
                end
            end
        end
        InValid = 0;
        tick();
        checks++;
        if (bWrEn !== 1'b0 || bCount !== 3'd4 || bErrCode !== 2'd2 || aWrEn !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold: bWrEn=%b Count=%0d ErrCode=%0d aWrEn=%b expected 0 4 2 0",
                     bWrEn, bCount, bErrCode, aWrEn);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_recover();
        test_gapped();
        test_async_reset();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
